qam_slicer: RTL

- Parametrised hard-decision slicer; successor to the BPSK/QPSK slicer in the baseband receive chain.
- Takes equalised {I,Q} Q1.15 symbols on an AXIS-like input and makes Gray-coded decisions for BPSK, QPSK, 16-QAM or 64-QAM.
- Packs the decided bits into OUT_W-bit words with selectable bit order, and propagates frame end with a valid-bit count.
- Control comes from ports driven by the existing AXI-Lite register shell; this block contains no bus logic.

---
 rtl/qam_slicer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/qam_slicer.sv
// Hard-decision BPSK/QPSK/16-QAM/64-QAM slicer that packs Gray-coded decisions into OUT_W-bit words.
// Statistics counters are built only when QAM_SLICER_STATS_EN is defined.
`timescale 1ns/1ps
module qam_slicer #(
    parameter int unsigned        OUT_W     = 8,
    parameter int unsigned        ACC_W     = 32,
    parameter int unsigned        MAX_BPS   = 6,
    parameter bit                 MSB_FIRST = 1'b0,
    parameter logic signed [15:0] DEF_THR   = 16'sd9459
) (
    input  logic                         clk_bb_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic                         sw_reset_i,
    input  logic [2:0]                   mode_i,
    input  logic [15:0]                  thr_a_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [31:0]                  in_data_i,
    input  logic                         in_last_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [OUT_W-1:0]             out_data_o,
    output logic                         out_last_o,
    output logic [$clog2(OUT_W+1)-1:0]   out_nbits_o,
    output logic                         err_mode_o,
    output logic [31:0]                  sym_count_o,
    output logic [31:0]                  word_count_o,
    output logic [31:0]                  frame_count_o
);
    localparam int unsigned CntW = $clog2(ACC_W + 1) + 1;
    localparam int unsigned NbW  = $clog2(OUT_W + 1);

    if (OUT_W < 8 || OUT_W > 32) begin : g_bad_out_w
        $error("qam_slicer: OUT_W must be in 8..32");
    end
    if (ACC_W < OUT_W + 6) begin : g_bad_acc_w
        $error("qam_slicer: ACC_W must be >= OUT_W+6");
    end

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic             eof_pend_q, frame_q, run_q, err_q;
    logic [1:0]       mode_q;
    logic             out_valid_q, out_last_q;
    logic [OUT_W-1:0] out_data_q;
    logic [NbW-1:0]   out_nbits_q;

    logic [2:0]       act_mode, k;
    logic             mode_legal, accept, full, load, last_d;
    logic [CntW-1:0]  room, nbits, rem, base;
    logic [15:0]      thr;
    logic [3:0]       dq, di;
    logic [5:0]       sym;
    logic [OUT_W-1:0] word;

    // Returns {sign, |x|>=T, |x|>=2T, T<=|x|<3T}
    function automatic logic [3:0] decide(input logic [15:0] x, input logic [17:0] t1);
        logic [16:0] a;
        logic [17:0] a18, t2, t3;
        logic        ge1;
        a = x[15] ? (17'd0 - {x[15], x}) : {1'b0, x};
        if (a > 17'd32767) a = 17'd32767;
        a18 = {1'b0, a};
        t2  = t1 << 1;
        t3  = t1 + t2;
        ge1 = a18 >= t1;
        return {x[15], ge1, a18 >= t2, ge1 & (a18 < t3)};
    endfunction

    always_comb begin
        act_mode   = frame_q ? {1'b0, mode_q} : mode_i;
        mode_legal = (act_mode <= 3'd2) || (act_mode == 3'd3 && MAX_BPS >= 6);
        unique case (act_mode[1:0])
            2'd0:    k = 3'd1;
            2'd1:    k = 3'd2;
            2'd2:    k = 3'd4;
            default: k = 3'd6;
        endcase
        room = CntW'(ACC_W) - bit_cnt_q;
        // A frame end must reach the output before the next frame's bits can merge with it
        in_ready_o = run_q & enable_i & mode_legal & ~sw_reset_i & ~eof_pend_q
                   & ~(out_valid_q & out_last_q) & (room >= CntW'(k));
        accept = in_valid_i & in_ready_o;

        // A zero threshold is meaningless; fall back to the register-shell reset value
        thr = (thr_a_i == 16'd0) ? $unsigned(DEF_THR) : thr_a_i;
        dq  = decide(in_data_i[15:0], {2'b00, thr});
        di  = decide(in_data_i[31:16], {2'b00, thr});
        unique case (act_mode[1:0])
            2'd0:    sym = {5'b0, di[3]};
            2'd1:    sym = {4'b0, di[3], dq[3]};
            2'd2:    sym = {2'b0, di[2], di[3], dq[2], dq[3]};
            default: sym = {di[0], di[1], di[3], dq[0], dq[1], dq[3]};
        endcase

        full   = bit_cnt_q >= CntW'(OUT_W);
        load   = run_q & (~out_valid_q | out_ready_i)
               & (full | (eof_pend_q & (bit_cnt_q != '0)));
        nbits  = full ? CntW'(OUT_W) : bit_cnt_q;
        rem    = load ? nbits : '0;
        base   = bit_cnt_q - rem;
        last_d = eof_pend_q & (bit_cnt_q <= CntW'(OUT_W));

        acc_d     = (acc_q >> rem) | (accept ? (ACC_W'(sym) << base) : '0);
        bit_cnt_d = base + (accept ? CntW'(k) : '0);

        // Bits above bit_cnt are always zero, so a partial word arrives already padded
        word = acc_q[OUT_W-1:0];
        if (MSB_FIRST) begin
            for (int i = 0; i < OUT_W; i++) word[OUT_W-1-i] = acc_q[i];
        end
    end

    always_ff @(posedge clk_bb_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q       <= '0;
            bit_cnt_q   <= '0;
            eof_pend_q  <= 1'b0;
            frame_q     <= 1'b0;
            mode_q      <= 2'd0;
            run_q       <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_nbits_q <= '0;
        end else if (sw_reset_i) begin
            acc_q       <= '0;
            bit_cnt_q   <= '0;
            eof_pend_q  <= 1'b0;
            frame_q     <= 1'b0;
            run_q       <= 1'b1;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_nbits_q <= '0;
        end else begin
            run_q     <= 1'b1;
            acc_q     <= acc_d;
            bit_cnt_q <= bit_cnt_d;
            if (accept && !frame_q) mode_q <= mode_i[1:0];
            if (accept) frame_q <= 1'b1;
            else if (out_valid_q && out_ready_i && out_last_q) frame_q <= 1'b0;
            if (accept && in_last_i) eof_pend_q <= 1'b1;
            else if (load && last_d) eof_pend_q <= 1'b0;
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= word;
                out_last_q  <= last_d;
                out_nbits_q <= NbW'(nbits);
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
            if (enable_i && !mode_legal) err_q <= 1'b1;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign out_nbits_o = out_nbits_q;
    assign err_mode_o  = err_q;

`ifdef QAM_SLICER_STATS_EN
    logic [31:0] sym_cnt_q, word_cnt_q, frm_cnt_q;

    always_ff @(posedge clk_bb_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sym_cnt_q  <= '0;
            word_cnt_q <= '0;
            frm_cnt_q  <= '0;
        end else begin
            if (accept && sym_cnt_q != '1) sym_cnt_q <= sym_cnt_q + 32'd1;
            if (out_valid_q && out_ready_i && word_cnt_q != '1) word_cnt_q <= word_cnt_q + 32'd1;
            if (out_valid_q && out_ready_i && out_last_q && frm_cnt_q != '1) begin
                frm_cnt_q <= frm_cnt_q + 32'd1;
            end
        end
    end

    assign sym_count_o   = sym_cnt_q;
    assign word_count_o  = word_cnt_q;
    assign frame_count_o = frm_cnt_q;
`else
    assign sym_count_o   = 32'd0;
    assign word_count_o  = 32'd0;
    assign frame_count_o = 32'd0;
`endif

endmodule
